axis_stream_master: RTL and testbench
=====================================

# axis_stream_master

Parametrised AXI4-Stream master that buffers backend beats in an internal synchronous FIFO and drives them onto an AXI-Stream bus with full valid/ready compliance. The backend supplies tlast per beat and gets standard backpressure. A compile-time mode selects cut-through or store-and-forward packet release. The block sits between user-project backend logic and the fsic AXIS fabric.

## Interface
- DATA_W, 32: tdata width; multiple of 8.
- USER_W, 2: tuser width.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- STORE_FWD, 0: 0 = cut-through; 1 = hold a packet until its tlast beat is buffered.
- TIMEOUT, 5: consecutive stalled cycles before bk_nordy asserts; 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous flush.
- bk_valid  in  1  backend beat valid.
- bk_ready  out  1  FIFO can accept a beat.
- bk_data  in  DATA_W  beat data.
- bk_tstrb, bk_tkeep  in  DATA_W/8  byte qualifiers.
- bk_user  in  USER_W  sideband.
- bk_last  in  1  last beat of packet.
- bk_nordy  out  1  tready stall timeout.
- bk_done  out  1  one-cycle pulse per completed packet.
- fifo_level  out  $clog2(DEPTH)+1  entries held.
- axis_tvalid, axis_tlast  out  1 each.
- axis_tdata  out  DATA_W.
- axis_tstrb, axis_tkeep  out  DATA_W/8.
- axis_tuser  out  USER_W.
- axis_tready  in  1.

## Operation
- FIFO entry = {data, tstrb, tkeep, user, last}. The entry is written on bk_valid && bk_ready.
- bk_ready = (level < DEPTH). A beat is not accepted when the FIFO is full, even if a read occurs in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Level is unchanged on a simultaneous read and write.
- The FIFO is first-word-fall-through. AXIS outputs show the head entry whenever axis_tvalid=1, and are all zero otherwise.
- pkt_cnt counts buffered tlast beats:
  - +1 on a write with last.
  - −1 on a handshake with tlast.
  - Unchanged when both happen in the same cycle.
- FSM states:
  - IDLE:
    - STORE_FWD=0: go to STREAM when level>0.
    - STORE_FWD=1: go to STREAM when pkt_cnt>0 or level==DEPTH. The level==DEPTH condition prevents deadlock on an oversized packet.
  - STREAM:
    - axis_tvalid = (level>0).
    - Go to IDLE on a handshake (tvalid && tready) with tlast=1.
- axis_tvalid is 0 in IDLE.
- Once tvalid is asserted, the head entry and all outputs are held stable until tready.
- The stall counter:
  - Increments, saturating at 255, on each cycle with tvalid && !tready.
  - Clears on a handshake or when tvalid=0.
  - bk_nordy = (counter ≥ TIMEOUT).
- bk_done is registered and pulses the cycle after each tlast handshake.
- clear takes priority over a write, a read and FSM transitions in the same cycle:
  - Effect at the next edge: pointers, level, pkt_cnt and stall counter go to 0, and the FSM goes to IDLE.
  - Beats presented with clear are dropped.
  - No bk_done pulse is generated.
  - clear is an error-recovery path only. It may withdraw tvalid without a handshake.

## Timing
- Reset values:
  - All outputs 0, except bk_ready=1.
  - FSM in IDLE; level, pkt_cnt and counters 0.
- Cut-through latency: a beat written at edge N gives axis_tvalid=1 after edge N+1 (one cycle for the IDLE→STREAM state update).
- Back-to-back throughput is 1 beat/cycle while level>0 and tready=1.
- Between packets there is one IDLE cycle (STREAM→IDLE→STREAM).
- Store-and-forward: tvalid rises one cycle after the edge that writes the tlast beat.
- Reset asserted mid-packet aborts immediately. No bk_done is generated.

## Structure
- Package axis_stream_pkg holds:
  - The FSM state enum {IDLE, STREAM}.
  - A function computing FIFO entry width from DATA_W/USER_W.
  - The stall-counter saturation constant 8'hFF.
- Sub-module axis_sync_fifo: parametrised FWFT FIFO with WIDTH, DEPTH, clear, level and full/empty outputs.
- The top level holds the FSM, pkt_cnt, stall counter and bk_done register.

## Test plan
- Cut-through single beat: bk_data=32'hA5A5_0001, last=1, tready=1 → tvalid at cycle+2, tlast=1, bk_done the next cycle, level returns to 0.
- Full/backpressure: DEPTH=8, tready=0, write 9 beats → bk_ready=0 after 8, level=8, ninth beat not accepted until a read. bk_nordy asserts after 5 stalled cycles and clears on the first handshake.
- Store-and-forward: 4-beat packet written with gaps, tready=1 → no tvalid until the 4th beat is written. Then 4 consecutive beats, tlast on the 4th.
- Oversize STORE_FWD: 10-beat packet into DEPTH=8 → release at level==8, all 10 beats delivered in order with a single tlast.
- Stall stability: randomised tready toggling on a 16-beat stream → payload unchanged while tvalid && !tready, order and tlast preserved.
- clear mid-packet, plus reset mid-packet: clear at beat 3 of 6 → tvalid=0 next cycle, level=0, no bk_done. A following 2-beat packet streams correctly.

Source files
------------

// File: rtl/axis_stream_pkg.sv
// Shared types and helpers for the AXI4-Stream master slice.
// Entry layout: {data, tstrb, tkeep, user, last}.
package axis_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam logic [7:0] STALL_MAX = 8'hFF;

  function automatic int entry_w(int dw, int uw);
    return dw + 2 * (dw / 8) + uw + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and fill level.
// Head entry is visible on rd_data whenever empty is low.
module axis_sync_fifo
  import axis_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_ok, rd_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  assign wr_ok = wr_en && !full && !clear;
  assign rd_ok = rd_en && !empty && !clear;

  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/axis_stream_master.sv
// AXI4-Stream master: buffers backend beats and releases them
// cut-through or store-and-forward with stall timeout reporting.
module axis_stream_master
  import axis_stream_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int USER_W    = 2,
  parameter int DEPTH     = 8,
  parameter int STORE_FWD = 0,
  parameter int TIMEOUT   = 5,
  localparam int SW = DATA_W / 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              bk_valid,
  output logic              bk_ready,
  input  logic [DATA_W-1:0] bk_data,
  input  logic [SW-1:0]     bk_tstrb,
  input  logic [SW-1:0]     bk_tkeep,
  input  logic [USER_W-1:0] bk_user,
  input  logic              bk_last,
  output logic              bk_nordy,
  output logic              bk_done,
  output logic [LW-1:0]     fifo_level,
  output logic              axis_tvalid,
  output logic              axis_tlast,
  output logic [DATA_W-1:0] axis_tdata,
  output logic [SW-1:0]     axis_tstrb,
  output logic [SW-1:0]     axis_tkeep,
  output logic [USER_W-1:0] axis_tuser,
  input  logic              axis_tready
);

  localparam int EW = entry_w(DATA_W, USER_W);

  state_e         state_q;
  logic [LW-1:0]  pkt_q;
  logic [7:0]     stall_q;
  logic           done_q;

  logic [EW-1:0]     wr_ent, rd_ent;
  logic [DATA_W-1:0] h_data;
  logic [SW-1:0]     h_strb, h_keep;
  logic [USER_W-1:0] h_user;
  logic              h_last;
  logic              full, empty;
  logic              hs, wr_fire, wr_last, rd_last, go;

  assign wr_ent = {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last};

  axis_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .wr_en   (bk_valid),
    .wr_data (wr_ent),
    .rd_en   (hs),
    .rd_data (rd_ent),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  assign {h_data, h_strb, h_keep, h_user, h_last} = rd_ent;

  assign bk_ready    = !full;
  assign axis_tvalid = (state_q == STREAM) && !empty;
  assign hs          = axis_tvalid && axis_tready;

  assign axis_tdata = axis_tvalid ? h_data : '0;
  assign axis_tstrb = axis_tvalid ? h_strb : '0;
  assign axis_tkeep = axis_tvalid ? h_keep : '0;
  assign axis_tuser = axis_tvalid ? h_user : '0;
  assign axis_tlast = axis_tvalid && h_last;

  assign wr_fire = bk_valid && !full && !clear;
  assign wr_last = wr_fire && bk_last;
  assign rd_last = hs && h_last && !clear;

  // A full FIFO releases even without tlast so oversized packets drain.
  assign go = (STORE_FWD != 0) ? ((pkt_q != '0) || full) : !empty;

  assign bk_nordy = (stall_q >= 8'(TIMEOUT));
  assign bk_done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= rd_last;

      unique case (1'b1)
        (wr_last && !rd_last): pkt_q <= pkt_q + LW'(1);
        (rd_last && !wr_last): pkt_q <= pkt_q - LW'(1);
        default:               pkt_q <= pkt_q;
      endcase

      if (axis_tvalid && !axis_tready) begin
        if (stall_q != STALL_MAX) stall_q <= stall_q + 8'd1;
      end else begin
        stall_q <= '0;
      end

      unique case (state_q)
        IDLE:    if (go) state_q <= STREAM;
        STREAM:  if (rd_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_master.sv
// Directed bench: cut-through and store-and-forward instances share
// stimulus; sel picks which instance a test observes.
module tb_axis_stream_master;

  localparam int LW = 4;
  typedef logic [42:0] ent_t;

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic        last;
    logic        etv;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  elv;
    logic        edone;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        bk_valid = 1'b0;
  logic        bk_last = 1'b0;
  logic        axis_tready = 1'b0;
  logic [31:0] bk_data = '0;
  logic [3:0]  bk_tstrb, bk_tkeep;
  logic [1:0]  bk_user;

  logic          rdy_o [2];
  logic          nordy_o [2];
  logic          done_o [2];
  logic          tv_o [2];
  logic          tl_o [2];
  logic [LW-1:0] lvl_o [2];
  logic [31:0]   td_o [2];
  logic [3:0]    ts_o [2];
  logic [3:0]    tk_o [2];
  logic [1:0]    tu_o [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   sel = 0;
  bit   prev_stall = 1'b0;
  ent_t prev_ent = '0;
  ent_t rx_q [$];
  vec_t vt [9];

  assign bk_tstrb = bk_data[3:0];
  assign bk_tkeep = ~bk_data[3:0];
  assign bk_user  = bk_data[1:0];

  always #5 clk = ~clk;

  axis_stream_master #(.STORE_FWD(0)) u_ct (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bk_valid(bk_valid), .bk_ready(rdy_o[0]),
    .bk_data(bk_data), .bk_tstrb(bk_tstrb),
    .bk_tkeep(bk_tkeep), .bk_user(bk_user),
    .bk_last(bk_last), .bk_nordy(nordy_o[0]),
    .bk_done(done_o[0]), .fifo_level(lvl_o[0]),
    .axis_tvalid(tv_o[0]), .axis_tlast(tl_o[0]),
    .axis_tdata(td_o[0]), .axis_tstrb(ts_o[0]),
    .axis_tkeep(tk_o[0]), .axis_tuser(tu_o[0]),
    .axis_tready(axis_tready)
  );

  axis_stream_master #(.STORE_FWD(1)) u_sf (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bk_valid(bk_valid), .bk_ready(rdy_o[1]),
    .bk_data(bk_data), .bk_tstrb(bk_tstrb),
    .bk_tkeep(bk_tkeep), .bk_user(bk_user),
    .bk_last(bk_last), .bk_nordy(nordy_o[1]),
    .bk_done(done_o[1]), .fifo_level(lvl_o[1]),
    .axis_tvalid(tv_o[1]), .axis_tlast(tl_o[1]),
    .axis_tdata(td_o[1]), .axis_tstrb(ts_o[1]),
    .axis_tkeep(tk_o[1]), .axis_tuser(tu_o[1]),
    .axis_tready(axis_tready)
  );

  function automatic ent_t ent(logic [31:0] d, logic l);
    return {d, d[3:0], ~d[3:0], d[1:0], l};
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample();
    ent_t cur;
    cur = {td_o[sel], ts_o[sel], tk_o[sel], tu_o[sel], tl_o[sel]};
    if (prev_stall) begin
      cmp("stall_valid", 64'(tv_o[sel]), 64'd1);
      cmp("stall_hold", 64'(cur), 64'(prev_ent));
    end
    if (!tv_o[sel]) cmp("idle_zero", 64'(cur), 64'd0);
    if (tv_o[sel] && axis_tready && !clear) rx_q.push_back(cur);
    prev_stall = tv_o[sel] && !axis_tready && !clear;
    prev_ent = cur;
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bk_valid = 1'b0;
    bk_last = 1'b0;
    bk_data = '0;
    axis_tready = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_q.delete();
  endtask

  task automatic check_rx(int n, logic [31:0] base, int plen);
    cmp("rx_count", 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      cmp("rx_beat", 64'(rx_q[i]),
          64'(ent(base + 32'(i), (i % plen == plen - 1) || (i == n - 1))));
  endtask

  task automatic run_stream(int n, logic [31:0] base, int plen,
                            bit rnd, output int first);
    int wi;
    wi = 0;
    first = -1;
    rx_q.delete();
    for (int c = 0; c < 400 && rx_q.size() < n; c++) begin
      bk_valid = (wi < n) && (!rnd || ($urandom_range(0, 3) != 0));
      bk_data = base + 32'(wi);
      bk_last = (wi % plen == plen - 1) || (wi == n - 1);
      axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (tv_o[sel] && first < 0) first = int'(lvl_o[sel]);
      sample();
      if (bk_valid && rdy_o[sel]) wi++;
      @(posedge clk);
      #1;
    end
    bk_valid = 1'b0;
    bk_last = 1'b0;
    axis_tready = 1'b0;
    check_rx(n, base, plen);
  endtask

  task automatic write_beats(int n, logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bk_valid = 1'b1;
      bk_data = base + 32'(i);
      bk_last = 1'b0;
      cyc();
    end
    bk_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;

    vt[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
    vt[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd1, 1'b0};
    vt[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 4'd1, 1'b0};
    vt[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1};
    vt[4] = '{1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0};
    vt[5] = '{1'b1, 32'h0000_0022, 1'b1, 1'b0, 32'h0, 1'b0, 4'd1, 1'b0};
    vt[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0011, 1'b0, 4'd2, 1'b0};
    vt[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0022, 1'b1, 4'd1, 1'b0};
    vt[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b1};

    // reset state
    #1;
    cmp("rst_ready", 64'(rdy_o[0]), 64'd1);
    cmp("rst_tvalid", 64'(tv_o[0]), 64'd0);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cmp("rst_ready", 64'(rdy_o[k]), 64'd1);
      cmp("rst_level", 64'(lvl_o[k]), 64'd0);
      cmp("rst_done", 64'(done_o[k]), 64'd0);
      cmp("rst_nordy", 64'(nordy_o[k]), 64'd0);
      cmp("rst_tvalid", 64'(tv_o[k]), 64'd0);
    end

    // cut-through table
    sel = 0;
    axis_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bk_valid = vt[i].vld;
      bk_data = vt[i].d;
      bk_last = vt[i].last;
      @(negedge clk);
      cmp("ct_tvalid", 64'(tv_o[0]), 64'(vt[i].etv));
      cmp("ct_tdata", 64'(td_o[0]), 64'(vt[i].ed));
      cmp("ct_tlast", 64'(tl_o[0]), 64'(vt[i].el));
      cmp("ct_level", 64'(lvl_o[0]), 64'(vt[i].elv));
      cmp("ct_done", 64'(done_o[0]), 64'(vt[i].edone));
      sample();
      @(posedge clk);
      #1;
    end

    // full / backpressure / stall timeout
    do_reset();
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      bk_valid = 1'b1;
      bk_data = 32'hB000_0000 + 32'(i);
      bk_last = 1'b0;
      @(negedge clk);
      if (i == 6) cmp("nordy_below", 64'(nordy_o[0]), 64'd0);
      if (i == 7) cmp("nordy_at", 64'(nordy_o[0]), 64'd1);
      sample();
      @(posedge clk);
      #1;
    end
    bk_data = 32'hB000_0008;
    bk_last = 1'b1;
    @(negedge clk);
    cmp("full_level", 64'(lvl_o[0]), 64'd8);
    cmp("full_ready", 64'(rdy_o[0]), 64'd0);
    sample();
    @(posedge clk);
    #1;
    axis_tready = 1'b1;
    @(negedge clk);
    cmp("full_hold", 64'(lvl_o[0]), 64'd8);
    cmp("full_ready2", 64'(rdy_o[0]), 64'd0);
    sample();
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("read_no_wr", 64'(lvl_o[0]), 64'd7);
    cmp("nordy_clr", 64'(nordy_o[0]), 64'd0);
    cmp("ready_back", 64'(rdy_o[0]), 64'd1);
    sample();
    @(posedge clk);
    #1;
    bk_valid = 1'b0;
    bk_last = 1'b0;
    for (int c = 0; c < 40 && rx_q.size() < 9; c++) cyc();
    check_rx(9, 32'hB000_0000, 9);

    // store-and-forward with gaps
    do_reset();
    sel = 1;
    axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bk_valid = 1'b1;
      bk_data = 32'hC000_0000 + 32'(i);
      bk_last = (i == 3);
      @(negedge clk);
      cmp("sf_hold", 64'(tv_o[1]), 64'd0);
      sample();
      @(posedge clk);
      #1;
      bk_valid = 1'b0;
      bk_last = 1'b0;
      @(negedge clk);
      cmp("sf_hold_gap", 64'(tv_o[1]), 64'd0);
      sample();
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmp("sf_tvalid", 64'(tv_o[1]), 64'd1);
      cmp("sf_tdata", 64'(td_o[1]), 64'(32'hC000_0000 + 32'(k)));
      cmp("sf_tlast", 64'(tl_o[1]), 64'(k == 3));
      sample();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cmp("sf_end_tvalid", 64'(tv_o[1]), 64'd0);
    cmp("sf_done", 64'(done_o[1]), 64'd1);
    sample();
    @(posedge clk);
    #1;

    // oversize packet in store-and-forward
    do_reset();
    sel = 1;
    run_stream(10, 32'hE000_0000, 10, 1'b0, first);
    cmp("sf_release_lvl", 64'(first), 64'd8);

    // random backpressure stability
    do_reset();
    sel = 0;
    run_stream(16, 32'hD000_0000, 4, 1'b1, first);

    // clear mid-packet
    do_reset();
    sel = 0;
    write_beats(3, 32'hF000_0000);
    bk_valid = 1'b1;
    bk_data = 32'hF000_0003;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    bk_valid = 1'b0;
    @(negedge clk);
    cmp("clr_tvalid", 64'(tv_o[0]), 64'd0);
    cmp("clr_level", 64'(lvl_o[0]), 64'd0);
    cmp("clr_done", 64'(done_o[0]), 64'd0);
    cmp("clr_nordy", 64'(nordy_o[0]), 64'd0);
    sample();
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("clr_done2", 64'(done_o[0]), 64'd0);
    sample();
    @(posedge clk);
    #1;
    run_stream(2, 32'h1200_0000, 2, 1'b0, first);

    // reset mid-packet
    do_reset();
    sel = 0;
    write_beats(3, 32'h3300_0000);
    cyc();
    rst_n = 1'b0;
    #1;
    cmp("arst_tvalid", 64'(tv_o[0]), 64'd0);
    cmp("arst_level", 64'(lvl_o[0]), 64'd0);
    cmp("arst_ready", 64'(rdy_o[0]), 64'd1);
    cmp("arst_done", 64'(done_o[0]), 64'd0);
    cmp("arst_nordy", 64'(nordy_o[0]), 64'd0);
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_stream(2, 32'h4400_0000, 2, 1'b0, first);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
